// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request bus between the memory-access stage and the data memory.
interface dmem_responder_if;
    logic        read_en;
    logic        write_en;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic [31:0] rdata_out;
    logic        ready;
    logic        err;
    logic        busy;
    modport master (
        output read_en, write_en, funct3_in, addr_in, wdata_in,
        input  rdata_out, ready, err, busy
    );
    modport slave (
        input  read_en, write_en, funct3_in, addr_in, wdata_in,
        output rdata_out, ready, err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: RV32I data-memory slave with size/alignment/range checks,
// little-endian byte lanes and sign/zero-extended loads.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input logic             clk,
    input logic             rst_n,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;
    state_t        state, nxt;
    logic [3:0]    cnt;
    logic [AW+1:0] addr;
    logic [31:0]   wdata;
    logic [2:0]    funct3;
    logic          is_wr;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          req, f3_ok, mis, oor, bad, done;
    logic [31:0]   word, rext, wlane;
    logic [15:0]   sh;
    logic [3:0]    be;
    assign req   = bus.read_en | bus.write_en;
    assign f3_ok = bus.write_en ? bus.funct3_in inside {3'b000, 3'b001, 3'b010}
                                : bus.funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign mis   = (bus.funct3_in[1:0] == 2'd1 && bus.addr_in[0]) ||
                   (bus.funct3_in[1:0] == 2'd2 && bus.addr_in[1:0] != 2'd0);
    assign oor   = bus.addr_in[31:2] >= 30'(DEPTH_WORDS);
    assign bad   = (bus.read_en & bus.write_en) | !f3_ok | mis | oor;
    assign done  = state == ACCESS && cnt == 4'd0;
    assign bus.ready = state == RESP || state == ERR;
    assign bus.err   = state == ERR;
    assign bus.busy  = state != IDLE;
    always_comb begin
        nxt = state;
        nxt = state == IDLE   ? (req ? (bad ? ERR : ACCESS) : IDLE) :
              state == ACCESS ? (cnt == 4'd0 ? RESP : ACCESS) : IDLE;
    end
    // Latched fields are only trusted once the request passed the checks.
    assign word  = mem[addr[AW+1:2]];
    assign sh    = 16'(word >> {addr[1:0], 3'b000});
    assign rext  = funct3[1] ? word :
                   funct3[0] ? {funct3[2] ? 16'b0 : {16{sh[15]}}, sh} :
                               {funct3[2] ? 24'b0 : {24{sh[7]}}, sh[7:0]};
    assign be    = funct3[1] ? 4'hf : funct3[0] ? (addr[1] ? 4'hc : 4'h3) : 4'b0001 << addr[1:0];
    assign wlane = funct3[1] ? wdata : funct3[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    always_ff @(posedge clk) state <= rst_n ? nxt : IDLE;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt           <= 4'd0;
            bus.rdata_out <= '0;
        end else if (state == IDLE && req) begin
            addr   <= bus.addr_in[AW+1:0];
            wdata  <= bus.wdata_in;
            funct3 <= bus.funct3_in;
            is_wr  <= bus.write_en;
            cnt    <= 4'(WAIT_STATES);
            if (bad && bus.read_en) bus.rdata_out <= '0;
        end else if (state == ACCESS && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end else if (done && !is_wr) begin
            bus.rdata_out <= rext;
        end
    end
    // RAM has no reset; a reset on the write edge suppresses the store.
    always_ff @(posedge clk)
        if (rst_n && done && is_wr)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[addr[AW+1:2]][8*i +: 8] <= wlane[8*i +: 8];
endmodule
